// File: rtl/monitor_pkg.sv
// Shared widths, the sample word layout and a chunk popcount helper for the infection monitor.
package monitor_pkg;

  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned EPOCH_W     = 16;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned CHUNK_W     = 32;
  localparam int unsigned CHUNK_CNT_W = 6;

  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [COUNT_W-1:0] infected;
  } sample_t;

  // Number of set bits in one 32-bit chunk (0..32 fits in 6 bits).
  function automatic logic [CHUNK_CNT_W-1:0] popcount_chunk(input logic [CHUNK_W-1:0] v);
    logic [CHUNK_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      n = n + CHUNK_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/infection_monitor_if.sv
// Valid/ready stream carrying tagged sample words from the monitor to the host/logging path.
interface infection_monitor_if;
  import monitor_pkg::*;

  logic    statValid;
  sample_t statData;
  logic    statReady;

  modport master (output statValid, output statData, input statReady);
  modport slave  (input statValid, input statData, output statReady);
endinterface

// File: rtl/stat_fifo.sv
// Synchronous first-word-fall-through FIFO of sample words with a registered head output.
module stat_fifo
  import monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  sample_t              push_data,
  output logic                 full,
  input  logic                 pop,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] occupancy,
  output sample_t              head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  sample_t            mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [OCC_W-1:0]   occ_n;
  logic               do_pop_c;
  logic               do_push_c;
  sample_t            head_n;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop_c  = pop && !empty;
    do_push_c = push && (!full || do_pop_c);
    rd_ptr_n  = rd_ptr + PTR_W'(do_pop_c);
    occ_n     = occupancy + OCC_W'(do_push_c) - OCC_W'(do_pop_c);
    head_n    = head;
    if (occ_n != '0) begin
      head_n = (do_push_c && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      head      <= '0;
    end else begin
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr + PTR_W'(do_push_c);
      occupancy <= occ_n;
      empty     <= (occ_n == '0);
      full      <= (occ_n == OCC_W'(DEPTH));
      head      <= head_n;
    end
  end

endmodule

// File: rtl/infection_monitor.sv
// Per-epoch infected-agent census with a popcount pipeline and buffered sample stream.
// Define INFECTION_MONITOR_PEAK_EN to build the peak count/epoch tracker.
module infection_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned NUM_AGENTS   = 100,
  parameter int unsigned EPOCH_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [NUM_AGENTS-1:0] agentStates,
  infection_monitor_if.master   stat,
  output logic                  extinct,
  output logic [COUNT_W-1:0]    dropCount,
  output logic [COUNT_W-1:0]    peakCount,
  output logic [EPOCH_W-1:0]    peakEpoch
);

  localparam int unsigned CYC_W      = $clog2(EPOCH_CYCLES);
  localparam int unsigned NUM_CHUNKS = (NUM_AGENTS + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH) + 1;

  logic [CYC_W-1:0]       cyc;
  logic [EPOCH_W-1:0]     epoch;
  logic                   sample_c;

  logic                   s0_valid;
  logic [NUM_AGENTS-1:0]  s0_states;
  logic [EPOCH_W-1:0]     s0_epoch;
  logic [PAD_W-1:0]       s0_padded;

  logic                   s1_valid;
  logic [CHUNK_CNT_W-1:0] s1_cnt [NUM_CHUNKS];
  logic [EPOCH_W-1:0]     s1_epoch;

  logic [COUNT_W-1:0]     s2_infected;
  sample_t                s2_sample;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [OCC_W-1:0]       fifo_occupancy;
  sample_t                fifo_head;

  assign sample_c = run && (cyc == CYC_W'(EPOCH_CYCLES - 1));

  // Epoch timing: cyc only moves while run is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc   <= '0;
      epoch <= '0;
    end else if (run) begin
      cyc <= sample_c ? '0 : cyc + CYC_W'(1);
      if (sample_c) begin
        epoch <= epoch + EPOCH_W'(1);
      end
    end
  end

  // S0 captures the agent vector and its epoch tag on the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= sample_c;
    end
    if (sample_c) begin
      s0_states <= agentStates;
      s0_epoch  <= epoch;
    end
  end

  assign s0_padded = PAD_W'(s0_states);

  // S1 reduces each 32-bit chunk; the top chunk is zero-padded.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
    end
    if (s0_valid) begin
      s1_epoch <= s0_epoch;
      for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
        s1_cnt[i] <= popcount_chunk(s0_padded[i*CHUNK_W +: CHUNK_W]);
      end
    end
  end

  always_comb begin
    s2_infected = '0;
    for (int i = 0; i < int'(NUM_CHUNKS); i++) begin
      s2_infected = s2_infected + COUNT_W'(s1_cnt[i]);
    end
    s2_sample.epoch    = s1_epoch;
    s2_sample.infected = s2_infected;
  end

  assign fifo_pop = !fifo_empty && stat.statReady;

  stat_fifo #(.DEPTH(FIFO_DEPTH)) u_stat_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (s2_sample),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .occupancy (fifo_occupancy),
    .head      (fifo_head)
  );

  assign stat.statValid = !fifo_empty;
  assign stat.statData  = fifo_head;

  // Extinction and drop accounting look at every completed sample, pushed or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      extinct   <= 1'b0;
      dropCount <= '0;
    end else if (s1_valid) begin
      if (s2_infected == '0) begin
        extinct <= 1'b1;
      end
      if (fifo_full && !fifo_pop && (dropCount != '1)) begin
        dropCount <= dropCount + COUNT_W'(1);
      end
    end
  end

`ifdef INFECTION_MONITOR_PEAK_EN
  // Strictly greater keeps the epoch of the first occurrence on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      peakCount <= '0;
      peakEpoch <= '0;
    end else if (s1_valid && (s2_infected > peakCount)) begin
      peakCount <= s2_infected;
      peakEpoch <= s1_epoch;
    end
  end
`else
  assign peakCount = '0;
  assign peakEpoch = '0;
`endif

  occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_occupancy <= OCC_W'(FIFO_DEPTH));

endmodule
